a_rom_sequencer: RTL

- Read scheduler for the A-matrix coefficient ROM: 8x4 matrix, 7-bit elements, column-major, two elements per 14-bit word, 16 words, 1-cycle registered read latency.
- Generates the ROM address stream and presents each word to the downstream MAC datapath through a valid/ready handshake, with column/row-pair tags.
- Can replay the full matrix for a programmable number of passes, e.g. once per B-vector.

---
 rtl/a_mat_pkg.sv | 31 +++
 rtl/a_seq_addr_gen.sv | 60 ++++++
 rtl/a_rom_sequencer.sv | 97 +++++++++
 3 files changed

// File: rtl/a_mat_pkg.sv
// Shared definitions for the A-matrix coefficient path: geometry of the
// 8x4 column-major ROM image, the read-sequencer state encoding, and helpers
// that split a word address into its column and row-pair fields.
package a_mat_pkg;

    localparam int A_ADDR_W        = 4;  // 16 words
    localparam int A_WORDS_PER_COL = 4;  // 8 rows, two elements per word
    localparam int A_NUM_COLS      = 4;
    localparam int A_ELEM_W        = 7;  // one matrix element

    localparam int A_PAIR_W = $clog2(A_WORDS_PER_COL);
    localparam int A_COL_W  = $clog2(A_NUM_COLS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } a_seq_state_e;

    // Column of a word address: the upper address bits.
    function automatic logic [A_COL_W-1:0] a_col_of(input logic [A_ADDR_W-1:0] addr);
        return addr[A_ADDR_W-1:A_PAIR_W];
    endfunction

    // Row pair within the column: the lower address bits.
    function automatic logic [A_PAIR_W-1:0] a_pair_of(input logic [A_ADDR_W-1:0] addr);
        return addr[A_PAIR_W-1:0];
    endfunction

endpackage

// File: rtl/a_seq_addr_gen.sv
// Address and pass counter for the A-ROM sequencer. rom_addr is the
// combinational address presented to the ROM this cycle; data_addr is the
// address the ROM latched on the previous edge, i.e. the word now on its output.
module a_seq_addr_gen
    import a_mat_pkg::*;
#(
    parameter int ADDR_W    = A_ADDR_W,
    parameter int PASS_W    = 4,
    parameter int LAST_ADDR = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,        // accepted start
    input  logic [PASS_W-1:0] pass_count,
    input  logic              stream,      // word on ROM output is being presented
    input  logic              advance,     // presented word accepted downstream
    output logic [ADDR_W-1:0] rom_addr,
    output logic [ADDR_W-1:0] data_addr,
    output logic [PASS_W-1:0] pass_idx,
    output logic              matrix_end,  // presented word is the last of the matrix
    output logic              final_pass
);

    logic [PASS_W-1:0] passes;

    assign matrix_end = (data_addr == ADDR_W'(LAST_ADDR));
    assign final_pass = (pass_idx == passes - PASS_W'(1));

    // Next ROM address: step on acceptance (wrapping to 0 after the last
    // word), re-read the same word under stall, park at 0 outside streaming.
    always_comb begin
        // NOTE: every output of a combinational block is given a value on every
        // path, starting with a default, so no latch is inferred.
        rom_addr = '0;
        if (stream) begin
            if (advance) rom_addr = matrix_end ? '0 : data_addr + ADDR_W'(1);
            else         rom_addr = data_addr;
        end
    end

    // Track the ROM's captured address and the pass count/index.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop in the
        // design samples values from before the edge, independent of block order.
        if (rst) begin
            data_addr <= '0;
            pass_idx  <= '0;
            passes    <= PASS_W'(1);
        end else begin
            data_addr <= rom_addr;
            if (load) begin
                passes   <= (pass_count == '0) ? PASS_W'(1) : pass_count;
                pass_idx <= '0;
            end else if (advance && matrix_end && !final_pass) begin
                pass_idx <= pass_idx + PASS_W'(1);
            end
        end
    end

endmodule

// File: rtl/a_rom_sequencer.sv
// Read scheduler for the A-matrix coefficient ROM (1-cycle registered read).
// Streams the 16 words of the matrix, optionally several passes back to back,
// over a valid/ready handshake with column/row-pair tags.
// Build option: define A_SEQ_PERF_CNT_EN to build the stall_cycles counter;
// without it stall_cycles is tied to zero.
module a_rom_sequencer
    import a_mat_pkg::*;
#(
    parameter int ADDR_W        = A_ADDR_W,
    parameter int WORDS_PER_COL = A_WORDS_PER_COL,
    parameter int NUM_COLS      = A_NUM_COLS,
    parameter int PASS_W        = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PASS_W-1:0] pass_count,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              a_valid,
    input  logic              a_ready,
    output logic [1:0]        col_idx,
    output logic [1:0]        pair_idx,
    output logic              col_last,
    output logic [PASS_W-1:0] pass_idx,
    output logic              busy,
    output logic              done,
    output logic [15:0]       stall_cycles
);

    a_seq_state_e      state;
    a_seq_state_e      state_next;
    logic [ADDR_W-1:0] data_addr;
    logic              start_ok;
    logic              handshake;
    logic              matrix_end;
    logic              final_pass;

    assign start_ok  = (state == ST_IDLE) && start;
    assign a_valid   = (state == ST_STREAM);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign handshake = a_valid && a_ready;

    assign col_idx  = a_col_of(data_addr);
    assign pair_idx = a_pair_of(data_addr);
    assign col_last = (pair_idx == 2'(WORDS_PER_COL - 1));

    // Sequencer control: PRIME gives the ROM one cycle to produce word 0,
    // STREAM runs until the last word of the last pass is accepted.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_PRIME;
            ST_PRIME:  state_next = ST_STREAM;
            ST_STREAM: if (handshake && matrix_end && final_pass) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    a_seq_addr_gen #(
        .ADDR_W    (ADDR_W),
        .PASS_W    (PASS_W),
        .LAST_ADDR (WORDS_PER_COL * NUM_COLS - 1)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (start_ok),
        .pass_count (pass_count),
        .stream     (a_valid),
        .advance    (handshake),
        .rom_addr   (rom_addr),
        .data_addr  (data_addr),
        .pass_idx   (pass_idx),
        .matrix_end (matrix_end),
        .final_pass (final_pass)
    );

`ifdef A_SEQ_PERF_CNT_EN
    // Count presented-but-not-accepted cycles per run; saturating, held after done.
    always_ff @(posedge clk) begin
        if (rst || start_ok)
            stall_cycles <= '0;
        else if (a_valid && !a_ready && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'd1;
    end
`else
    assign stall_cycles = '0;
`endif

endmodule
